// File: rtl/us_sensor_scheduler.sv
// Round-robin ultrasonic ranging controller: one trigger/echo timing datapath shared by
// NUM_SENSORS HC-SR04-style sensors, reporting each distance in cm with a one-cycle strobe.
module us_sensor_scheduler #(
  parameter int NUM_SENSORS     = 4,
  parameter int IDX_W           = 2,
  parameter int CLK_PER_US      = 50,
  parameter int TRIG_US         = 10,
  parameter int ECHO_TIMEOUT_US = 30000,
  parameter int GAP_US          = 60000
) (
  input  logic                   CLK50MHZ,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [NUM_SENSORS-1:0] sensor_mask,
  input  logic [NUM_SENSORS-1:0] echo,
  output logic [NUM_SENSORS-1:0] trig,
  output logic                   busy,
  output logic                   result_valid,
  output logic [IDX_W-1:0]       result_id,
  output logic [8:0]             result_cm,
  output logic                   result_timeout
);

  localparam int PRESC_W = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam int US_MAX0 = (ECHO_TIMEOUT_US > GAP_US) ? ECHO_TIMEOUT_US : GAP_US;
  localparam int US_MAX  = (US_MAX0 > TRIG_US) ? US_MAX0 : TRIG_US;
  localparam int US_W    = $clog2(US_MAX + 1);

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_PER_US - 1);
  localparam logic [US_W-1:0]    TRIG_LAST  = US_W'(TRIG_US - 1);
  localparam logic [US_W-1:0]    ECHO_LAST  = US_W'(ECHO_TIMEOUT_US - 1);
  localparam logic [US_W-1:0]    GAP_LAST   = US_W'(GAP_US - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_SENSORS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_TRIG, S_WAIT_RISE, S_MEASURE, S_DONE, S_GAP
  } state_t;

  state_t                 state;
  logic [NUM_SENSORS-1:0] echo_meta;
  logic [NUM_SENSORS-1:0] echo_sync;
  logic [PRESC_W-1:0]     presc;
  logic [US_W-1:0]        us_cnt;
  logic [IDX_W-1:0]       cur;
  logic [IDX_W-1:0]       ptr;
  logic [IDX_W-1:0]       hi_idx;
  logic [IDX_W-1:0]       lo_idx;
  logic [IDX_W-1:0]       sel_idx;
  logic                   hi_found;
  logic                   lo_found;
  logic                   tick;
  logic                   echo_cur;

  assign tick     = (presc == PRESC_LAST);
  assign echo_cur = echo_sync[cur];

  // Round trip at 340 m/s: cm = us * 0.017, truncated and clamped to the 9-bit field.
  function automatic logic [8:0] conv_cm(input logic [US_W-1:0] n);
    logic [31:0] q;
    q = (32'(n) * 32'd17) / 32'd1000;
    return (q > 32'd511) ? 9'd511 : q[8:0];
  endfunction

  // First masked-in sensor at or above ptr, else the lowest masked-in sensor (wrap).
  // NOTE: every always_comb output is given a default first so no latch is inferred.
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_found = 1'b0;
    lo_idx   = '0;
    for (int i = 0; i < NUM_SENSORS; i++) begin
      if (sensor_mask[i]) begin
        if (!lo_found) begin
          lo_found = 1'b1;
          lo_idx   = IDX_W'(i);
        end
        if (!hi_found && (IDX_W'(i) >= ptr)) begin
          hi_found = 1'b1;
          hi_idx   = IDX_W'(i);
        end
      end
    end
    sel_idx = hi_found ? hi_idx : lo_idx;
  end

  always_ff @(posedge CLK50MHZ or posedge reset) begin
    if (reset) begin
      echo_meta <= '0;
      echo_sync <= '0;
    end else begin
      echo_meta <= echo;
      echo_sync <= echo_meta;
    end
  end

  // NOTE: state is updated with <= only; a later assignment in the same branch overrides
  // the free-running counter default, which is how every state entry clears the timebase.
  always_ff @(posedge CLK50MHZ or posedge reset) begin
    if (reset) begin
      state          <= S_IDLE;
      trig           <= '0;
      busy           <= 1'b0;
      result_valid   <= 1'b0;
      result_id      <= '0;
      result_cm      <= '0;
      result_timeout <= 1'b0;
      presc          <= '0;
      us_cnt         <= '0;
      cur            <= '0;
      ptr            <= '0;
    end else begin
      result_valid <= 1'b0;
      if (tick) begin
        presc  <= '0;
        us_cnt <= us_cnt + 1'b1;
      end else begin
        presc  <= presc + 1'b1;
      end

      case (state)
        S_IDLE: begin
          presc  <= '0;
          us_cnt <= '0;
          if (enable && lo_found) begin
            state <= S_TRIG;
            cur   <= sel_idx;
            ptr   <= (sel_idx == IDX_LAST) ? '0 : sel_idx + 1'b1;
            trig  <= NUM_SENSORS'(1) << sel_idx;
            busy  <= 1'b1;
          end
        end

        S_TRIG: begin
          if (tick && (us_cnt == TRIG_LAST)) begin
            state  <= S_WAIT_RISE;
            trig   <= '0;
            presc  <= '0;
            us_cnt <= '0;
          end
        end

        S_WAIT_RISE: begin
          if (echo_cur) begin
            state  <= S_MEASURE;
            presc  <= '0;
            us_cnt <= '0;
          end else if (tick && (us_cnt == ECHO_LAST)) begin
            state          <= S_DONE;
            result_valid   <= 1'b1;
            result_id      <= cur;
            result_cm      <= '0;
            result_timeout <= 1'b1;
            presc          <= '0;
            us_cnt         <= '0;
          end
        end

        S_MEASURE: begin
          if (!echo_cur) begin
            state          <= S_DONE;
            result_valid   <= 1'b1;
            result_id      <= cur;
            result_cm      <= conv_cm(us_cnt);
            result_timeout <= 1'b0;
            presc          <= '0;
            us_cnt         <= '0;
          end else if (tick && (us_cnt == ECHO_LAST)) begin
            state          <= S_DONE;
            result_valid   <= 1'b1;
            result_id      <= cur;
            result_cm      <= 9'd511;
            result_timeout <= 1'b1;
            presc          <= '0;
            us_cnt         <= '0;
          end
        end

        S_DONE: begin
          state  <= S_GAP;
          presc  <= '0;
          us_cnt <= '0;
        end

        S_GAP: begin
          if (tick && (us_cnt == GAP_LAST)) begin
            state  <= S_IDLE;
            busy   <= 1'b0;
            presc  <= '0;
            us_cnt <= '0;
          end
        end

        default: begin
          state <= S_IDLE;
          trig  <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_us_sensor_scheduler.sv
// Self-checking bench for us_sensor_scheduler: directed scenarios plus randomized echoes,
// scored against a round-robin / echo-width model built from plain arithmetic.
module tb_us_sensor_scheduler;

  localparam int N       = 4;
  localparam int CPU     = 2;
  localparam int TRIG_US = 10;
  localparam int TO_US   = 1000;
  localparam int GAP_US  = 50;

  logic         CLK50MHZ = 1'b0;
  logic         reset;
  logic         enable;
  logic [N-1:0] sensor_mask;
  logic [N-1:0] echo;
  logic [N-1:0] trig;
  logic         busy;
  logic         result_valid;
  logic [1:0]   result_id;
  logic [8:0]   result_cm;
  logic         result_timeout;

  int checks     = 0;
  int errors     = 0;
  int strobe_cnt = 0;
  int onehot_bad = 0;
  int trig_cycles [N] = '{default: 0};
  int model_ptr  = 0;
  bit noise_en   = 1'b0;

  us_sensor_scheduler #(
    .NUM_SENSORS(N), .IDX_W(2), .CLK_PER_US(CPU), .TRIG_US(TRIG_US),
    .ECHO_TIMEOUT_US(TO_US), .GAP_US(GAP_US)
  ) dut (
    .CLK50MHZ(CLK50MHZ), .reset(reset), .enable(enable), .sensor_mask(sensor_mask),
    .echo(echo), .trig(trig), .busy(busy), .result_valid(result_valid),
    .result_id(result_id), .result_cm(result_cm), .result_timeout(result_timeout)
  );

  always #10 CLK50MHZ = ~CLK50MHZ;

  always @(negedge CLK50MHZ) begin
    if (result_valid === 1'b1) strobe_cnt++;
    if (!$onehot0(trig)) onehot_bad++;
    for (int i = 0; i < N; i++) if (trig[i] === 1'b1) trig_cycles[i]++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  function automatic int model_pick(input logic [N-1:0] mask);
    for (int k = 0; k < N; k++) begin
      int j = (model_ptr + k) % N;
      if (mask[j]) return j;
    end
    return 0;
  endfunction

  function automatic int model_cm(input int us);
    int v = (us * 17) / 1000;
    return (v > 511) ? 511 : v;
  endfunction

  task automatic drive_echo(input int tgt, input logic val);
    logic [N-1:0] ev;
    ev = noise_en ? N'($urandom) : '0;
    ev[tgt] = val;
    echo = ev;
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    enable = 1'b0;
    echo   = '0;
    repeat (3) @(negedge CLK50MHZ);
    reset     = 1'b0;
    model_ptr = 0;
  endtask

  // One measurement: width = echo-high clocks after trig falls (0 = no echo);
  // pre_high holds the echo high from before the trigger.
  task automatic run_one(input string tag, input int delay, input int width,
                         input bit pre_high, input int drop_at);
    int exp_id, exp_cm, c, len;
    bit exp_to, seen;
    exp_id    = model_pick(sensor_mask);
    model_ptr = (exp_id + 1) % N;
    // Rise is seen on one clock; the remaining high clocks are timed in whole us.
    if (pre_high) begin
      exp_to = 1'b1; exp_cm = 511;
    end else if (width == 0) begin
      exp_to = 1'b1; exp_cm = 0;
    end else if (width - 1 >= TO_US * CPU) begin
      exp_to = 1'b1; exp_cm = 511;
    end else begin
      exp_to = 1'b0; exp_cm = model_cm((width - 1) / CPU);
    end

    seen = 1'b0;
    for (int n = 0; n < 400 && !seen; n++) begin
      drive_echo(exp_id, pre_high);
      @(negedge CLK50MHZ);
      seen = (trig !== '0);
    end
    check({tag, "/trig_seen"}, 32'(seen), 1);
    if (!seen) return;
    check({tag, "/trig_sel"}, 32'(trig), 1 << exp_id);

    len = 0;
    while (trig[exp_id] === 1'b1 && len < 100) begin
      len++;
      drive_echo(exp_id, pre_high);
      @(negedge CLK50MHZ);
    end
    check({tag, "/trig_len"}, len, TRIG_US * CPU);

    seen = 1'b0;
    c    = 0;
    while (!seen && c < 6000) begin
      drive_echo(exp_id, pre_high || (c >= delay && c < delay + width));
      if (c == drop_at) enable = 1'b0;
      @(negedge CLK50MHZ);
      c++;
      seen = (result_valid === 1'b1);
    end
    check({tag, "/result_seen"}, 32'(seen), 1);
    if (!seen) return;
    check({tag, "/id"}, 32'(result_id), exp_id);
    check({tag, "/cm"}, 32'(result_cm), exp_cm);
    check({tag, "/timeout"}, 32'(result_timeout), 32'(exp_to));
    check({tag, "/busy"}, 32'(busy), 1);
    if (width == 0 && !pre_high) check({tag, "/latency"}, c, TO_US * CPU);
    @(negedge CLK50MHZ);
    check({tag, "/strobe_1cyc"}, 32'(result_valid), 0);
    check({tag, "/cm_hold"}, 32'(result_cm), exp_cm);
  endtask

  initial begin
    int snap, n;
    bit seen;
    reset = 1'b1; enable = 1'b0; sensor_mask = '0; echo = '0;
    repeat (2) @(negedge CLK50MHZ);
    check("rst/trig", 32'(trig), 0);
    check("rst/busy", 32'(busy), 0);
    check("rst/valid", 32'(result_valid), 0);
    check("rst/id", 32'(result_id), 0);
    check("rst/cm", 32'(result_cm), 0);
    check("rst/timeout", 32'(result_timeout), 0);

    // Basic single sensor, 580 us echo.
    do_reset();
    sensor_mask = 4'b0001; enable = 1'b1;
    snap = strobe_cnt;
    run_one("basic", 3, 580 * CPU, 1'b0, -1);
    check("basic/strobes", strobe_cnt - snap, 1);

    // Round robin 0,1,3,0 with 800 us echoes; sensor 2 masked out.
    do_reset();
    sensor_mask = 4'b1011; enable = 1'b1;
    snap = trig_cycles[2];
    for (int i = 0; i < 4; i++) run_one("rr", 2, 800 * CPU, 1'b0, -1);
    check("rr/trig2_never", trig_cycles[2] - snap, 0);

    // No echo on sensor 1.
    do_reset();
    sensor_mask = 4'b0010; enable = 1'b1;
    run_one("noecho", 0, 0, 1'b0, -1);

    // Stuck echo on sensor 0, then next trigger after DONE + GAP + IDLE select cycle.
    do_reset();
    sensor_mask = 4'b0001; enable = 1'b1;
    run_one("stuck", 0, 0, 1'b1, -1);
    n = 1; seen = 1'b0;
    while (!seen && n < 300) begin
      @(negedge CLK50MHZ);
      n++;
      seen = (trig !== '0);
    end
    check("stuck/next_trig", n, 1 + GAP_US * CPU + 1);

    // Echo width boundary around the timeout.
    do_reset();
    echo = '0; sensor_mask = 4'b0001; enable = 1'b1;
    run_one("edge_below", 2, TO_US * CPU, 1'b0, -1);
    run_one("edge_at", 2, TO_US * CPU + 1, 1'b0, -1);

    // Enable dropped mid-MEASURE: result still emitted, then park.
    do_reset();
    sensor_mask = 4'b0001; enable = 1'b1;
    run_one("endrop", 5, 1000, 1'b0, 25);
    repeat (GAP_US * CPU - 1) @(negedge CLK50MHZ);
    check("endrop/busy_gap_end", 32'(busy), 1);
    @(negedge CLK50MHZ);
    check("endrop/busy_idle", 32'(busy), 0);
    snap = trig_cycles[0] + trig_cycles[1] + trig_cycles[2] + trig_cycles[3];
    repeat (300) @(negedge CLK50MHZ);
    check("endrop/no_trig",
          trig_cycles[0] + trig_cycles[1] + trig_cycles[2] + trig_cycles[3] - snap, 0);
    check("endrop/still_idle", 32'(busy), 0);

    // Async reset during TRIG of sensor 1.
    do_reset();
    sensor_mask = 4'b1111; enable = 1'b1;
    run_one("ar_pre", 1, 400, 1'b0, -1);
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge CLK50MHZ);
      seen = (trig !== '0);
    end
    check("ar/trig1", 32'(trig), 4'b0010);
    repeat (5) @(negedge CLK50MHZ);
    snap = strobe_cnt;
    #2 reset = 1'b1;
    #1;
    check("ar/trig_async", 32'(trig), 0);
    check("ar/busy_async", 32'(busy), 0);
    check("ar/cm_async", 32'(result_cm), 0);
    @(negedge CLK50MHZ);
    @(negedge CLK50MHZ);
    reset = 1'b0; model_ptr = 0;
    run_one("ar_post", 1, 600, 1'b0, -1);
    check("ar/strobes", strobe_cnt - snap, 1);

    // Randomized masks, delays and widths with noise on the other echo pins.
    do_reset();
    enable = 1'b1; noise_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      int r, w;
      sensor_mask = 4'($urandom_range(1, 15));
      r = $urandom_range(0, 9);
      if (r == 0)      w = 0;
      else if (r == 1) w = $urandom_range(TO_US * CPU + 1, TO_US * CPU + 300);
      else             w = $urandom_range(1, TO_US * CPU - 10);
      run_one("rand", $urandom_range(0, 60), w, 1'b0, -1);
    end

    check("trig_onehot_violations", onehot_bad, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
